// File: rtl/motor_tx_pkg.sv
// Shared codes, ASCII constants and helpers for the motor status UART reporter.
package motor_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_FWD     = 3'b001,
    ST_LEFT    = 3'b010,
    ST_BRAKE   = 3'b011,
    ST_RIGHT   = 3'b100,
    ST_BACK    = 3'b101,
    ST_INVALID = 3'b111
  } motor_stat_e;

  localparam logic [7:0] CMD_FWD     = 8'h61;
  localparam logic [7:0] CMD_LEFT    = 8'h62;
  localparam logic [7:0] CMD_BRAKE   = 8'h63;
  localparam logic [7:0] CMD_RIGHT   = 8'h64;
  localparam logic [7:0] CMD_BACK    = 8'h65;
  localparam logic [7:0] CHR_IDLE    = 8'h78;
  localparam logic [7:0] CHR_INVALID = 8'h3F;
  localparam logic [7:0] CHR_LF      = 8'h0A;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [7:0] stat_to_ascii(input logic [2:0] stat);
    case (stat)
      ST_IDLE:  return CHR_IDLE;
      ST_FWD:   return CMD_FWD;
      ST_LEFT:  return CMD_LEFT;
      ST_BRAKE: return CMD_BRAKE;
      ST_RIGHT: return CMD_RIGHT;
      ST_BACK:  return CMD_BACK;
      default:  return CHR_INVALID;
    endcase
  endfunction

  // Uppercase hex: 'A' is 8'h41, i.e. 8'h37 + 10.
  function automatic logic [7:0] nib_to_hex(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/motor_status_tx_uart.sv
// Byte serializer (8N1, LSB first); a start accepted at the end of a stop bit
// chains the next byte with no idle gap.
module uart_tx_byte
  import motor_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            tick;

  assign tick   = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign done_o = (state_q == TX_STOP) && tick;
  assign busy_o = (state_q != TX_IDLE);
  assign tx_o   = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q != TX_IDLE) cnt_d = tick ? '0 : cnt_q + CW'(1);
    unique case (state_q)
      TX_IDLE: if (start_i) begin
        state_d = TX_START;
        cnt_d   = '0;
        shift_d = data_i;
        tx_d    = 1'b0;
      end
      TX_START: if (tick) begin
        state_d = TX_DATA;
        bit_d   = '0;
        tx_d    = shift_q[0];
      end
      TX_DATA: if (tick) begin
        if (bit_q == 3'd7) begin
          state_d = TX_STOP;
          tx_d    = 1'b1;
        end else begin
          bit_d   = bit_q + 3'd1;
          shift_d = {1'b0, shift_q[7:1]};
          tx_d    = shift_q[1];
        end
      end
      TX_STOP: if (tick) begin
        if (start_i) begin
          state_d = TX_START;
          shift_d = data_i;
          tx_d    = 1'b0;
        end else begin
          state_d = TX_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/motor_status_tx.sv
// Frame sequencer: sends "<motor><prox hex>\n" whenever the snapshotted status changes.
// Optional periodic resend when STATUS_HEARTBEAT_EN is defined.
module motor_status_tx
  import motor_tx_pkg::*;
#(
  parameter int CLK_FREQ         = 50_000_000,
  parameter int BAUD             = 115_200,
  parameter int CLKS_PER_BIT     = CLK_FREQ / BAUD,
  parameter int HEARTBEAT_CYCLES = 5_000_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] MOTOR_STAT,
  input  logic [3:0] PROX_STAT,
  input  logic       TX_EN,
  output logic       UART_TX,
  output logic       BUSY,
  output logic       FRAME_DONE
);

  logic       snap_vld_q, snap_vld_d;
  logic [6:0] snap_q, snap_d;
  logic       active_q, active_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic       done_q, done_d;
  logic       ser_start, ser_busy, ser_done;
  logic [7:0] ser_data;
  logic       hb_fire, trigger;

  assign trigger = TX_EN && !active_q && !ser_busy &&
                   (!snap_vld_q || ({MOTOR_STAT, PROX_STAT} != snap_q) || hb_fire);

`ifdef STATUS_HEARTBEAT_EN
  localparam int HBW = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  logic [HBW-1:0] hb_q;
  assign hb_fire = (hb_q == HBW'(HEARTBEAT_CYCLES - 1));
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        hb_q <= '0;
    else if (trigger)  hb_q <= '0;
    else if (!hb_fire) hb_q <= hb_q + HBW'(1);
  end
`else
  assign hb_fire = 1'b0;
`endif

  // B0 goes out on the trigger edge itself, so it comes from the inputs being latched.
  always_comb begin
    snap_vld_d = snap_vld_q;
    snap_d     = snap_q;
    active_d   = active_q;
    byte_idx_d = byte_idx_q;
    done_d     = 1'b0;
    ser_start  = 1'b0;
    ser_data   = stat_to_ascii(MOTOR_STAT);
    if (trigger) begin
      ser_start  = 1'b1;
      snap_d     = {MOTOR_STAT, PROX_STAT};
      snap_vld_d = 1'b1;
      active_d   = 1'b1;
      byte_idx_d = 2'd0;
    end else if (active_q && ser_done) begin
      if (byte_idx_q == 2'd2) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end else begin
        ser_start  = 1'b1;
        byte_idx_d = byte_idx_q + 2'd1;
        ser_data   = (byte_idx_q == 2'd0) ? nib_to_hex(snap_q[3:0]) : CHR_LF;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      snap_vld_q <= 1'b0;
      snap_q     <= '0;
      active_q   <= 1'b0;
      byte_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      snap_vld_q <= snap_vld_d;
      snap_q     <= snap_d;
      active_q   <= active_d;
      byte_idx_q <= byte_idx_d;
      done_q     <= done_d;
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .start_i (ser_start),
    .data_i  (ser_data),
    .tx_o    (UART_TX),
    .busy_o  (ser_busy),
    .done_o  (ser_done)
  );

  assign BUSY       = active_q;
  assign FRAME_DONE = done_q;

endmodule
